// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - boot loader byte stream, memory write ports and status
interface inst_loader_if #(
    parameter int INST_MEM_WIDTH = 14,
    parameter int PATTERN_WIDTH  = 10
);
    logic                      rx_valid;
    logic [7:0]                rx_data;
    logic                      rx_ready;
    logic                      imem_we;
    logic [INST_MEM_WIDTH-1:0] imem_addr;
    logic [31:0]               imem_wdata;
    logic                      pht_we;
    logic [PATTERN_WIDTH-1:0]  pht_addr;
    logic [1:0]                pht_wdata;
    logic                      core_hold;
    logic                      done;
    logic                      error;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output pht_we, pht_addr, pht_wdata, core_hold, done, error
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  pht_we, pht_addr, pht_wdata, core_hold, done, error
    );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot image loader into instruction memory, optional PHT sweep (INST_LOADER_PHT_CLEAR_EN)
module inst_loader #(
    parameter int INST_MEM_WIDTH = 14,
    parameter int PATTERN_WIDTH  = 10
) (
    input  logic           clk,
    input  logic           reset,
    inst_loader_if.master  bus
);
    localparam logic [31:0] CAPACITY = 32'(1) << INST_MEM_WIDTH;

    typedef enum logic [2:0] {
        HEADER,
        LOAD,
        CLEAR,
        DONE,
        ERROR
    } state_t;

`ifdef INST_LOADER_PHT_CLEAR_EN
    localparam state_t LOAD_EXIT = CLEAR;
`else
    localparam state_t LOAD_EXIT = DONE;
`endif

    state_t state, next_state;

    logic [1:0]                byte_idx;
    logic [31:0]               shift_reg;
    logic [INST_MEM_WIDTH:0]   word_count;
    logic [INST_MEM_WIDTH:0]   word_cnt;
    logic [INST_MEM_WIDTH:0]   word_cnt_inc;
    logic                      imem_we_r;
    logic [INST_MEM_WIDTH-1:0] imem_addr_r;

    logic        rx_ready;
    logic        core_hold;
    logic        done;
    logic        error;
    logic        accept;
    logic        word_complete;
    logic        last_word;
    logic [31:0] assembled;

`ifdef INST_LOADER_PHT_CLEAR_EN
    logic                     pht_we;
    logic [PATTERN_WIDTH-1:0] sweep_cnt;
    logic                     sweep_last;

    assign sweep_last = &sweep_cnt;
`endif

    assign accept        = bus.rx_valid && rx_ready;
    assign assembled     = {shift_reg[23:0], bus.rx_data};
    assign word_complete = accept && (byte_idx == 2'd3);
    assign word_cnt_inc  = word_cnt + 1'b1;
    assign last_word     = (word_cnt_inc == word_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HEADER;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rx_ready   = 1'b0;
        core_hold  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
`ifdef INST_LOADER_PHT_CLEAR_EN
        pht_we     = 1'b0;
`endif
        case (state)
            HEADER: begin
                rx_ready = 1'b1;
                if (word_complete) begin
                    // Full 32-bit compare so oversized headers cannot alias into range
                    if (assembled == 32'd0) begin
                        next_state = LOAD_EXIT;
                    end else if (assembled > CAPACITY) begin
                        next_state = ERROR;
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                rx_ready = 1'b1;
                if (word_complete && last_word) begin
                    next_state = LOAD_EXIT;
                end
            end
            CLEAR: begin
`ifdef INST_LOADER_PHT_CLEAR_EN
                pht_we = 1'b1;
                if (sweep_last) begin
                    next_state = DONE;
                end
`else
                next_state = DONE;
`endif
            end
            DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: begin
                next_state = HEADER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx    <= 2'd0;
            shift_reg   <= 32'd0;
            word_count  <= '0;
            word_cnt    <= '0;
            imem_we_r   <= 1'b0;
            imem_addr_r <= '0;
        end else begin
            imem_we_r <= 1'b0;
            if (accept) begin
                byte_idx  <= byte_idx + 2'd1;
                shift_reg <= assembled;
            end
            if (state == HEADER && word_complete) begin
                word_count <= assembled[INST_MEM_WIDTH:0];
            end
            if (state == LOAD && word_complete) begin
                imem_we_r   <= 1'b1;
                imem_addr_r <= word_cnt[INST_MEM_WIDTH-1:0];
                word_cnt    <= word_cnt_inc;
            end
        end
    end

`ifdef INST_LOADER_PHT_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_cnt <= '0;
        end else if (state == CLEAR) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    assign bus.pht_we    = pht_we;
    assign bus.pht_addr  = sweep_cnt;
    assign bus.pht_wdata = 2'b01;
`else
    assign bus.pht_we    = 1'b0;
    assign bus.pht_addr  = {PATTERN_WIDTH{1'b0}};
    assign bus.pht_wdata = 2'b00;
`endif

    // The shift register holds the complete word during the write cycle, so it drives wdata directly
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = shift_reg;
    assign bus.rx_ready   = rx_ready;
    assign bus.core_hold  = core_hold;
    assign bus.done       = done;
    assign bus.error      = error;
endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - randomized checking of inst_loader against a byte-count model
module tb_inst_loader;
    localparam int          IMW   = 4;
    localparam int          PW    = 2;
    localparam int          DEPTH = 1 << PW;
    localparam logic [31:0] CAP   = 32'(1) << IMW;
`ifdef INST_LOADER_PHT_CLEAR_EN
    localparam int SWEEP_EXP = DEPTH;
`else
    localparam int SWEEP_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_loader_if #(.INST_MEM_WIDTH(IMW), .PATTERN_WIDTH(PW)) bus ();
    inst_loader #(.INST_MEM_WIDTH(IMW), .PATTERN_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: expectations follow from how many bytes have been accepted so far
    bit          m_valid = 0;
    bit          m_err, m_done, m_we;
    int          m_bytes, m_n, m_sweep, m_addr;
    logic [31:0] m_acc, m_data;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_pht = 0;
    logic [7:0]  tx_q[$];

    function automatic bit m_ready();
        if (m_err || m_done || m_sweep >= 0) return 1'b0;
        if (m_n >= 0 && m_bytes >= 4 + 4 * m_n) return 1'b0;
        return 1'b1;
    endfunction

    task automatic finish_load();
`ifdef INST_LOADER_PHT_CLEAR_EN
        m_sweep = 0;
`else
        m_done = 1;
`endif
    endtask

    always @(negedge clk) begin
        bit rdy;
        if (m_valid) begin
            check("rx_ready", 32'(bus.rx_ready), 32'(m_ready()));
            check("imem_we", 32'(bus.imem_we), 32'(m_we));
            if (m_we) begin
                check("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
                check("imem_wdata", bus.imem_wdata, m_data);
            end
            check("pht_we", 32'(bus.pht_we), 32'(m_sweep >= 0));
`ifdef INST_LOADER_PHT_CLEAR_EN
            if (m_sweep >= 0) begin
                check("pht_addr", 32'(bus.pht_addr), 32'(m_sweep));
                check("pht_wdata", 32'(bus.pht_wdata), 32'd1);
            end
`else
            check("pht_addr_tied", 32'(bus.pht_addr), 32'd0);
            check("pht_wdata_tied", 32'(bus.pht_wdata), 32'd0);
`endif
            check("done", 32'(bus.done), 32'(m_done));
            check("error", 32'(bus.error), 32'(m_err));
            check("core_hold", 32'(bus.core_hold), 32'(!m_done));
        end
        if (bus.imem_we) begin
            obs_addr.push_back(32'(bus.imem_addr));
            obs_data.push_back(bus.imem_wdata);
        end
        if (bus.pht_we) obs_pht++;

        if (reset) begin
            m_valid = 1; m_bytes = 0; m_n = -1; m_err = 0; m_done = 0;
            m_sweep = -1; m_we = 0; m_acc = 32'd0; m_addr = 0; m_data = 32'd0;
        end else if (m_valid) begin
            rdy  = m_ready();
            m_we = 0;
            if (m_sweep >= 0) begin
                m_sweep++;
                if (m_sweep == DEPTH) begin
                    m_sweep = -1;
                    m_done  = 1;
                end
            end else if (rdy && bus.rx_valid) begin
                m_bytes++;
                m_acc = {m_acc[23:0], bus.rx_data};
                if (m_bytes == 4) begin
                    if (m_acc > CAP) m_err = 1;
                    else begin
                        m_n = int'(m_acc);
                        if (m_n == 0) finish_load();
                    end
                end else if (m_bytes % 4 == 0) begin
                    m_we   = 1;
                    m_addr = m_bytes / 4 - 2;
                    m_data = m_acc;
                    if (m_bytes == 4 + 4 * m_n) finish_load();
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        obs_pht = 0;
        tx_q.delete();
    endtask

    task automatic send(input int period, input int pct, input int budget);
        int  idx = 0;
        int  cyc = 0;
        bit  v;
        while (idx < tx_q.size() && cyc < budget) begin
            @(posedge clk); #1;
            v = ((cyc % period) == 0) && ($urandom_range(0, 99) < pct);
            bus.rx_valid = v;
            bus.rx_data  = v ? tx_q[idx] : 8'($urandom);
            @(negedge clk);
            if (bus.rx_valid && bus.rx_ready) idx++;
            cyc++;
            if (bus.done || bus.error) break;
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic junk(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            bus.rx_valid = 1'($urandom);
            bus.rx_data  = 8'($urandom);
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (bus.done || bus.error) hit = 1;
        end
        check("end_reached", 32'(hit), 32'd1);
    endtask

    initial begin
        logic [31:0] hdr;
        int          n;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_pht_we", 32'(bus.pht_we), 32'd0);
        check("rst_core_hold", 32'(bus.core_hold), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);

        // Two words at full rate
        do_reset();
        push_word(32'd2); push_word(32'hDEADBEEF); push_word(32'h01234567);
        send(1, 100, 200);
        wait_end(200);
        #1;
        check("t1_nwrites", 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            check("t1_addr0", obs_addr[0], 32'd0);
            check("t1_data0", obs_data[0], 32'hDEADBEEF);
            check("t1_addr1", obs_addr[1], 32'd1);
            check("t1_data1", obs_data[1], 32'h01234567);
        end
        check("t1_pht_cycles", 32'(obs_pht), 32'(SWEEP_EXP));

        // Empty image
        do_reset();
        push_word(32'd0);
        send(1, 100, 100);
        wait_end(100);
        #1;
        check("t2_nwrites", 32'(obs_addr.size()), 32'd0);
        check("t2_pht_cycles", 32'(obs_pht), 32'(SWEEP_EXP));
        check("t2_done", 32'(bus.done), 32'd1);

        // Oversized headers, including one that would alias to zero if truncated
        do_reset();
        push_word(32'h00000011);
        send(1, 100, 100);
        wait_end(50);
        junk(6);
        @(negedge clk);
        check("t3_error", 32'(bus.error), 32'd1);
        check("t3_core_hold", 32'(bus.core_hold), 32'd1);
        check("t3_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("t3_nwrites", 32'(obs_addr.size()), 32'd0);
        do_reset();
        @(negedge clk);
        check("t3_error_cleared", 32'(bus.error), 32'd0);
        do_reset();
        push_word(32'h00010000);
        send(1, 100, 100);
        wait_end(50);
        #1;
        check("t3_alias_error", 32'(bus.error), 32'd1);

        // Gapped input, one byte every third cycle
        do_reset();
        push_word(32'd1); push_word(32'hCAFEBABE);
        send(3, 100, 200);
        wait_end(100);
        #1;
        check("t4_nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_addr.size() == 1) begin
            check("t4_addr", obs_addr[0], 32'd0);
            check("t4_data", obs_data[0], 32'hCAFEBABE);
        end

        // Fill memory completely, then keep offering bytes
        do_reset();
        push_word(CAP);
        for (int i = 0; i < int'(CAP); i++) push_word($urandom);
        send(1, 100, 400);
        wait_end(100);
        junk(10);
        #1;
        check("t5_nwrites", 32'(obs_addr.size()), CAP);
        if (obs_addr.size() > 0) check("t5_last_addr", obs_addr[obs_addr.size() - 1], 32'hF);

        // Reset in the middle of the first data word
        do_reset();
        push_word(32'd3);
        tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
        send(1, 100, 100);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        tx_q.delete();
        push_word(32'd1); push_word(32'h11223344);
        send(1, 100, 100);
        wait_end(100);
        #1;
        check("t6_nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_addr.size() == 1) begin
            check("t6_addr", obs_addr[0], 32'd0);
            check("t6_data", obs_data[0], 32'h11223344);
        end
        check("t6_done", 32'(bus.done), 32'd1);

        // Randomized images, rates and interruptions
        for (int it = 0; it < 25; it++) begin
            do_reset();
            if ($urandom_range(0, 9) == 0) hdr = $urandom;
            else hdr = 32'($urandom_range(0, int'(CAP)));
            n = (hdr <= CAP) ? int'(hdr) : 0;
            push_word(hdr);
            for (int i = 0; i < n; i++) push_word($urandom);
            if ($urandom_range(0, 4) == 0) begin
                while (tx_q.size() > 1 && $urandom_range(0, 3) != 0) void'(tx_q.pop_back());
                send($urandom_range(1, 3), $urandom_range(40, 100), 2000);
            end else begin
                send($urandom_range(1, 3), $urandom_range(40, 100), 2000);
                wait_end(200);
                junk(5);
                #1;
                check("rand_nwrites", 32'(obs_addr.size()), 32'(n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
